// File: rtl/pll_ctrl_pkg.sv
// Purpose : shared state encoding and default parameter values for the PLL brake controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BRAKE     = 2'd1,
        WAIT_LOCK = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    localparam int BRAKE_PULSE_CYCLES_DEF = 4;
    localparam int LOCK_CONFIRM_DEF       = 16;
    localparam int LOCK_TIMEOUT_DEF       = 4096;
    localparam int HOLDOFF_CYCLES_DEF     = 64;
    localparam int DIVN_RESET_DEF         = 40;

    // Bits needed to hold values 0..maxv without wrapping.
    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/pll_brake_ctrl_if.sv
// Purpose : divider-request valid/ready handshake into the PLL brake controller.
// Latency : n/a (wiring only); ready is combinational in the slave.
// Backpressure: master holds divn_req stable while divn_req_valid is high and ready is low.
// Ports   : divn_req_valid, divn_req (32-bit signed divider), divn_req_ready.
interface pll_brake_ctrl_if;
    logic        divn_req_valid;
    logic [31:0] divn_req;
    logic        divn_req_ready;

    modport master (output divn_req_valid, output divn_req, input divn_req_ready);
    modport slave  (input divn_req_valid, input divn_req, output divn_req_ready);
endinterface

// File: rtl/pll_stat_cnt.sv
// Purpose : W-bit event counter that sticks at all-ones instead of wrapping.
// Latency : count reflects an inc pulse one refclk edge later.
// Backpressure: none; inc is a one-cycle strobe.
// Ports   : clk, resetn (sync, active-low), inc, count[W-1:0].
module pll_stat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pll_brake_ctrl.sv
// Purpose : brakes the PLL on supply droop, then waits for relock and a holdoff before new divider requests.
// Latency : divn updates on the accept edge; brake rises on the edge that enters BRAKE.
// Backpressure: divn_req_ready is low outside IDLE and while a droop event is waiting to be served.
// Ports   : refclk, resetn (sync, active-low), droop_req, req_if (divn request handshake),
//           pll_locked, brake, divn, busy, timeout_err; with PLL_BRAKE_STATS_EN defined
//           also brake_count[15:0] and timeout_count[7:0] (saturating event counters).
module pll_brake_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int BRAKE_PULSE_CYCLES = BRAKE_PULSE_CYCLES_DEF,
    parameter int LOCK_CONFIRM       = LOCK_CONFIRM_DEF,
    parameter int LOCK_TIMEOUT       = LOCK_TIMEOUT_DEF,
    parameter int HOLDOFF_CYCLES     = HOLDOFF_CYCLES_DEF,
    parameter int DIVN_RESET         = DIVN_RESET_DEF
) (
    input  logic               refclk,
    input  logic               resetn,
    input  logic               droop_req,
    pll_brake_ctrl_if.slave    req_if,
    input  logic               pll_locked,
    output logic               brake,
    output logic signed [31:0] divn,
    output logic               busy,
    output logic               timeout_err
`ifdef PLL_BRAKE_STATS_EN
    ,
    output logic [15:0]        brake_count,
    output logic [7:0]         timeout_count
`endif
);

    // One phase counter times BRAKE, WAIT_LOCK (timeout) and HOLDOFF; it is cleared
    // on every state change and each state exits before the count could overflow.
    localparam int PH_MAX0 = (BRAKE_PULSE_CYCLES > HOLDOFF_CYCLES) ? BRAKE_PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int PH_MAX  = (PH_MAX0 > LOCK_TIMEOUT) ? PH_MAX0 : LOCK_TIMEOUT;
    localparam int PH_W    = cnt_w(PH_MAX);
    localparam int CF_W    = cnt_w(LOCK_CONFIRM);

    state_t            state_q, state_d;
    logic              droop_q;
    logic              pending_q;
    logic [PH_W-1:0]   ph_cnt_q, ph_inc;
    logic [CF_W-1:0]   cf_cnt_q, cf_nxt;
    logic              brake_q;
    logic signed [31:0] divn_q;
    logic              err_q;

    logic droop_edge, accept, tmo_hit, enter_brake, state_chg;

    assign droop_edge            = droop_req & ~droop_q;
    assign req_if.divn_req_ready = (state_q == IDLE) & ~droop_edge & ~pending_q;
    assign accept                = req_if.divn_req_ready & req_if.divn_req_valid;

    // Counter values as they will be at the end of this cycle; exits compare
    // against these so a state lasts exactly its configured number of cycles.
    assign ph_inc = ph_cnt_q + PH_W'(1);
    assign cf_nxt = pll_locked ? (cf_cnt_q + CF_W'(1)) : '0;

    always_comb begin
        state_d = state_q;
        tmo_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (droop_edge || pending_q) begin
                    state_d = BRAKE;
                end else if (accept) begin
                    state_d = WAIT_LOCK;
                end
            end
            BRAKE: begin
                if (ph_inc == PH_W'(BRAKE_PULSE_CYCLES)) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Confirm is tested first so a simultaneous timeout is not flagged.
                if (cf_nxt == CF_W'(LOCK_CONFIRM)) begin
                    state_d = HOLDOFF;
                end else if (ph_inc == PH_W'(LOCK_TIMEOUT)) begin
                    state_d = HOLDOFF;
                    tmo_hit = 1'b1;
                end
            end
            HOLDOFF: begin
                if (ph_inc == PH_W'(HOLDOFF_CYCLES)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_chg   = (state_d != state_q);
    assign enter_brake = (state_d == BRAKE) && (state_q != BRAKE);

    always_ff @(posedge refclk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            droop_q   <= 1'b0;
            pending_q <= 1'b0;
            ph_cnt_q  <= '0;
            cf_cnt_q  <= '0;
            brake_q   <= 1'b0;
            divn_q    <= 32'(DIVN_RESET);
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            droop_q  <= droop_req;
            brake_q  <= (state_d == BRAKE);
            ph_cnt_q <= (state_chg || (state_q == IDLE)) ? '0 : ph_inc;
            cf_cnt_q <= (state_chg || (state_q != WAIT_LOCK)) ? '0 : cf_nxt;

            // Droops during BRAKE are absorbed by the pulse already running.
            if (enter_brake) begin
                pending_q <= 1'b0;
            end else if (droop_edge && ((state_q == WAIT_LOCK) || (state_q == HOLDOFF))) begin
                pending_q <= 1'b1;
            end

            if (accept) begin
                divn_q <= ($signed(req_if.divn_req) > 32'sd2) ? $signed(req_if.divn_req) : 32'sd2;
            end

            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign brake       = brake_q;
    assign divn        = divn_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = err_q;

`ifdef PLL_BRAKE_STATS_EN
    pll_stat_cnt #(.W(16)) u_brake_cnt (
        .clk    (refclk),
        .resetn (resetn),
        .inc    (enter_brake),
        .count  (brake_count)
    );

    pll_stat_cnt #(.W(8)) u_tmo_cnt (
        .clk    (refclk),
        .resetn (resetn),
        .inc    (tmo_hit),
        .count  (timeout_count)
    );
`endif

endmodule

// File: tb/tb_pll_brake_ctrl.sv
// Purpose : checks pll_brake_ctrl every cycle against a behavioural model under directed and random stimulus.
// Latency : n/a (testbench).
// Backpressure: n/a.
module tb_pll_brake_ctrl;

    localparam int BRK   = 4;
    localparam int CONF  = 16;
    localparam int TMO   = 100;
    localparam int HOLD  = 64;
    localparam int DIVN0 = 40;

    localparam int M_IDLE = 0, M_BRAKE = 1, M_WAIT = 2, M_HOLD = 3;

    logic        refclk = 1'b0;
    logic        resetn, droop_req, pll_locked;
    logic        brake, busy, timeout_err;
    logic [31:0] divn;
`ifdef PLL_BRAKE_STATS_EN
    logic [15:0] brake_count;
    logic [7:0]  timeout_count;
`endif

    always #5 refclk = ~refclk;

    pll_brake_ctrl_if req_if();

    pll_brake_ctrl #(
        .BRAKE_PULSE_CYCLES (BRK),
        .LOCK_CONFIRM       (CONF),
        .LOCK_TIMEOUT       (TMO),
        .HOLDOFF_CYCLES     (HOLD),
        .DIVN_RESET         (DIVN0)
    ) dut (
        .refclk      (refclk),
        .resetn      (resetn),
        .droop_req   (droop_req),
        .req_if      (req_if),
        .pll_locked  (pll_locked),
        .brake       (brake),
        .divn        (divn),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef PLL_BRAKE_STATS_EN
        ,
        .brake_count   (brake_count),
        .timeout_count (timeout_count)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: which phase we are in, how long we have been there,
    // how long pll_locked has been continuously high, and the sticky facts.
    int          m_mode    = M_IDLE;
    int          m_elapsed = 0;
    int          m_run     = 0;
    bit          m_pend    = 0;
    bit          m_dprev   = 0;
    bit          m_err     = 0;
    logic [31:0] m_divn    = DIVN0;
    int          m_brakes  = 0;
    int          m_touts   = 0;

    function automatic bit m_ready();
        return (m_mode == M_IDLE) && !(droop_req && !m_dprev) && !m_pend;
    endfunction

    task automatic m_go(input int mode);
        m_mode    = mode;
        m_elapsed = 0;
        m_run     = 0;
    endtask

    task automatic m_step();
        bit e;
        e = droop_req && !m_dprev;
        if (!resetn) begin
            m_go(M_IDLE);
            m_pend   = 0;
            m_dprev  = 0;
            m_err    = 0;
            m_divn   = DIVN0;
            m_brakes = 0;
            m_touts  = 0;
        end else begin
            m_dprev = droop_req;
            case (m_mode)
                M_IDLE: begin
                    if (e || m_pend) begin
                        m_go(M_BRAKE);
                        m_pend = 0;
                        if (m_brakes < 65535) m_brakes++;
                    end else if (req_if.divn_req_valid) begin
                        m_divn = ($signed(req_if.divn_req) > 2) ? req_if.divn_req : 32'd2;
                        m_go(M_WAIT);
                    end
                end
                M_BRAKE: begin
                    m_elapsed++;
                    if (m_elapsed == BRK) m_go(M_WAIT);
                end
                M_WAIT: begin
                    if (e) m_pend = 1;
                    m_elapsed++;
                    m_run = pll_locked ? m_run + 1 : 0;
                    if (m_run == CONF) begin
                        m_go(M_HOLD);
                    end else if (m_elapsed == TMO) begin
                        m_err = 1;
                        if (m_touts < 255) m_touts++;
                        m_go(M_HOLD);
                    end
                end
                default: begin
                    if (e) m_pend = 1;
                    m_elapsed++;
                    if (m_elapsed == HOLD) m_go(M_IDLE);
                end
            endcase
        end
    endtask

    // Brake-high cycles seen since the bench last cleared it.
    int brk_w = 0;
    always @(negedge refclk) if (brake === 1'b1) brk_w++;

    // One refclk cycle: compare registered outputs, apply new inputs, compare
    // ready, then advance the model on the same edge as the DUT.
    task automatic tick(input bit d, input bit v, input logic [31:0] r, input bit l, input bit rn);
        @(negedge refclk);
        check("brake", brake, m_mode == M_BRAKE);
        check("busy", busy, m_mode != M_IDLE);
        check("divn", divn, m_divn);
        check("timeout_err", timeout_err, m_err);
`ifdef PLL_BRAKE_STATS_EN
        check("brake_count", brake_count, m_brakes);
        check("timeout_count", timeout_count, m_touts);
`endif
        resetn                = rn;
        droop_req             = d;
        req_if.divn_req_valid = v;
        req_if.divn_req       = r;
        pll_locked            = l;
        #1;
        check("ready", req_if.divn_req_ready, m_ready());
        @(posedge refclk);
        m_step();
    endtask

    initial begin
        resetn                = 1'b0;
        droop_req             = 1'b0;
        pll_locked            = 1'b0;
        req_if.divn_req_valid = 1'b0;
        req_if.divn_req       = '0;
        repeat (3) @(posedge refclk);

        // Reset state, then one droop with the PLL relocking immediately.
        tick(0, 0, 0, 1, 1);
        #1;
        check("rst_divn", divn, 40);
        check("rst_brake", brake, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_if.divn_req_ready, 1);
        brk_w = 0;
        tick(1, 0, 0, 1, 1);
        repeat (83) tick(1, 0, 0, 1, 1);
        #1 check("relock_still_busy", busy, 1);
        tick(1, 0, 0, 1, 1);
        #1 check("relock_idle", busy, 0);
        check("brake_width", brk_w, 4);

        // Divider requests, including clamping to the minimum of 2.
        tick(0, 1, 55, 1, 1);
        #1 check("divn_55", divn, 55);
        check("divn_busy", busy, 1);
        repeat (82) tick(0, 0, 0, 1, 1);
        tick(0, 1, 1, 1, 1);
        #1 check("divn_clamp", divn, 2);
        repeat (82) tick(0, 0, 0, 1, 1);

        // Droop and request together: brake wins, request waits for IDLE.
        tick(1, 1, 77, 1, 1);
        #1 check("simul_brake", brake, 1);
        check("simul_divn_hold", divn, 2);
        repeat (84) tick(1, 1, 77, 1, 1);
        #1 check("simul_not_yet", divn, 2);
        tick(1, 1, 77, 1, 1);
        #1 check("simul_accept", divn, 77);
        repeat (82) tick(0, 0, 0, 1, 1);

        // Relock timeout, then a clean relock that leaves the flag set.
        tick(1, 0, 0, 0, 1);
        repeat (103) tick(1, 0, 0, 0, 1);
        #1 check("tmo_not_yet", timeout_err, 0);
        tick(1, 0, 0, 0, 1);
        #1 check("tmo_set", timeout_err, 1);
        repeat (66) tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        repeat (86) tick(1, 0, 0, 1, 1);
        #1 check("tmo_sticky", timeout_err, 1);
`ifdef PLL_BRAKE_STATS_EN
        check("tmo_count", timeout_count, 1);
`endif
        tick(0, 0, 0, 1, 1);

        // Droop in HOLDOFF is held pending; droop in BRAKE is merged.
        tick(1, 0, 0, 1, 1);
        repeat (40) tick(1, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        repeat (42) tick(1, 0, 0, 1, 1);
        #1 check("pend_idle_gap", brake, 0);
        brk_w = 0;
        tick(1, 0, 0, 1, 1);
        #1 check("pend_brake", brake, 1);
        tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        repeat (97) tick(1, 0, 0, 1, 1);
        check("merge_one_pulse", brk_w, 4);

        // Reset during the second brake cycle.
        tick(0, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 1);
        tick(1, 0, 0, 1, 0);
        #1 check("rst_mid_brake", brake, 0);
        check("rst_mid_busy", busy, 0);
`ifdef PLL_BRAKE_STATS_EN
        check("rst_mid_count", brake_count, 0);
`endif
        tick(1, 0, 0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] r;
            r = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
            tick($urandom_range(0, 19) == 0 ? ~droop_req : droop_req,
                 $urandom_range(0, 3) == 0,
                 r,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 599) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pll_brake_ctrl.md
PLL_BRAKE_CTRL -- requirements
Module: pll_brake_ctrl

Interface
REQ-001 Parameter BRAKE_PULSE_CYCLES, default 4: refclk cycles that brake is held high per brake event (legal 1..255).
REQ-002 Parameter LOCK_CONFIRM, default 16: consecutive refclk cycles of pll_locked high required to declare relock.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: maximum refclk cycles spent in WAIT_LOCK.
REQ-004 Parameter HOLDOFF_CYCLES, default 64: refclk cycles spent in HOLDOFF after each relock or timeout.
REQ-005 Parameter DIVN_RESET, default 40: divn value after reset.
REQ-006 refclk  in  1: sole clock; all logic on posedge refclk.
REQ-007 resetn  in  1: synchronous, active-low reset.
REQ-008 droop_req  in  1: level signal from the supply monitor; only its rising edge is significant.
REQ-009 divn_req_valid  in  1: new divider request is valid.
REQ-010 divn_req  in  32 (int): requested divider value.
REQ-011 divn_req_ready  out  1: a request is accepted when valid and ready are both high on the same edge.
REQ-012 pll_locked  in  1: PLL phase-lock status.
REQ-013 brake  out  1: brake request to the PLL.
REQ-014 divn  out  32 (int): divider value driven to the PLL.
REQ-015 busy  out  1: high whenever the state is not IDLE.
REQ-016 timeout_err  out  1: sticky relock-timeout flag.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, BRAKE, WAIT_LOCK and HOLDOFF.
REQ-018 Edge detection: droop_edge = droop_req & ~droop_q, where droop_q is droop_req registered on refclk.
REQ-019 In IDLE, a droop_edge or a set pending flag SHALL cause the next state to be BRAKE; this takes priority over a divn request.
REQ-020 divn_req_ready SHALL equal (state==IDLE) & ~droop_edge & ~pending, and SHALL be combinational.
REQ-021 On an accepted request, divn SHALL update on the same edge to max(divn_req, 2), and the next state SHALL be WAIT_LOCK.
REQ-022 In BRAKE, brake SHALL be high for exactly BRAKE_PULSE_CYCLES cycles, registered, starting the cycle after entry; the FSM then moves to WAIT_LOCK with brake low.
REQ-023 A droop_edge that occurs while in BRAKE SHALL be merged and ignored.
REQ-024 On entry to WAIT_LOCK, both the confirm counter and the timeout counter SHALL clear.
REQ-025 In WAIT_LOCK, pll_locked low SHALL reset the confirm counter.
REQ-026 When the confirm counter reaches LOCK_CONFIRM, the FSM SHALL go to HOLDOFF.
REQ-027 When the timeout counter reaches LOCK_TIMEOUT first, the FSM SHALL set timeout_err and go to HOLDOFF.
REQ-028 If confirm and timeout are reached on the same cycle, confirm SHALL win and timeout_err SHALL not be set.
REQ-029 HOLDOFF SHALL last HOLDOFF_CYCLES cycles and then return to IDLE.
REQ-030 A droop_edge in WAIT_LOCK or HOLDOFF SHALL set pending; pending SHALL clear on entry to BRAKE.
REQ-031 divn SHALL change only through the accepted-request path; it is unchanged by any brake event.
REQ-032 Counters SHALL be sized for their maximum parameter value and SHALL never wrap.

Reset
REQ-033 While resetn is low at a refclk edge, the following SHALL hold: state=IDLE, brake=0, divn=DIVN_RESET, timeout_err=0, pending=0, droop_q=0, all counters=0, busy=0.
REQ-034 Reset asserted mid-BRAKE SHALL drop brake on that same edge; no pending event survives reset.

Configuration
REQ-035 With PLL_BRAKE_STATS_EN defined, two outputs SHALL be added: brake_count (out, 16 bits), counting entries to BRAKE, and timeout_count (out, 8 bits), counting timeouts. Both saturate at all-ones and clear on reset.
REQ-036 Without PLL_BRAKE_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 Package pll_ctrl_pkg SHALL hold the state enum (IDLE, BRAKE, WAIT_LOCK, HOLDOFF) and the default parameter constants.
REQ-038 A single sub-module, pll_stat_cnt (parameterised-width saturating counter), SHALL be used, instantiated only under PLL_BRAKE_STATS_EN.

Verification
REQ-039 Reset scenario: after reset, divn=40, brake=0, busy=0, ready=1; droop_req rises -> brake is high for exactly 4 cycles; pll_locked held high -> IDLE after 16+64 cycles.
REQ-040 divn scenario: valid with divn_req=55 while IDLE -> divn=55 on the accept edge and busy=1; divn_req=1 -> divn=2.
REQ-041 Simultaneous scenario: droop_edge and divn_req_valid in the same IDLE cycle -> ready=0, BRAKE entered, divn unchanged; the request is accepted after return to IDLE.
REQ-042 Timeout scenario: pll_locked held low with LOCK_TIMEOUT=100 -> timeout_err=1 after 100 WAIT_LOCK cycles; it stays 1 through later successful relocks; timeout_count=1 with the macro defined.
REQ-043 Pending scenario: droop edge during HOLDOFF -> second BRAKE starts one cycle after return to IDLE; droop edge during BRAKE -> only one brake pulse occurs.
REQ-044 Reset scenario: resetn low during the 2nd brake cycle -> brake=0 and IDLE on that edge, and brake_count=0.
